wram_shadow_arbiter: RTL and testbench
======================================

Name: wram_shadow_arbiter

Overview:
Sits directly upstream of sdram_arbiter and maintains an 8 KB BSRAM shadow of the WRAM window shared by the NES CPU and the RISC-V IOSys core. All writes are mirrored into SDRAM, and all non-WRAM RV traffic is forwarded to SDRAM. WRAM reads from either master are served from the BSRAM. The block arbitrates the single BSRAM write port between CPU and RV, using i_wram_load_ongoing to select priority.

Parameters:
CPU_WRAM_BASE, 22'h006000, CPU byte address of WRAM window start.
RV_WRAM_BASE, 23'h066000, RV byte address of WRAM window start.
WRAM_BYTES, 8192, window size in bytes; power of two.

Ports:
i_clk  in  1  system clock
i_resetn  in  1  async active-low reset
i_wram_load_ongoing  in  1  1 = RV has BSRAM write priority
i_cpu_addr  in  22  CPU byte address
i_cpu_read  in  1  single-cycle read strobe
i_cpu_write  in  1  single-cycle write strobe
i_cpu_din  in  8  CPU write data
o_cpu_dout  out  8  BSRAM read data
o_cpu_hit  out  1  o_cpu_dout valid, from a WRAM hit
i_rv_addr  in  23  RV byte address
i_rv_word  in  1  selects upper 16-bit half
i_rv_wdata  in  32  RV write data
i_rv_wstrb  in  4  RV byte strobes; nonzero = write
i_rv_req  in  1  toggle request
o_rv_req_ack  out  1  toggle ack
o_rv_dout  out  16  RV read data
o_fwd_rv_req  out  1  toggle request to sdram_arbiter
i_fwd_rv_ack  in  1  toggle ack from sdram_arbiter
i_fwd_rv_dout  in  16  SDRAM read data
o_conflict_count  out  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending-CPU buffer empty.
- BSRAM organisation: 4096 x 16, byte lanes, read-first, 1-cycle read latency.
- CPU hit: i_cpu_addr in [CPU_WRAM_BASE, CPU_WRAM_BASE+WRAM_BYTES).
  - Lane = addr[0]; row = addr[12:1].
  - RV hit is defined the same way over RV_WRAM_BASE.
  - RV half index = {addr[12:2], i_rv_word}; RV byte enables = i_rv_word ? wstrb[3:2] : wstrb[1:0].
- CPU read hit: o_cpu_dout and o_cpu_hit=1 appear the cycle after i_cpu_read. A miss gives o_cpu_hit=0 and o_cpu_dout is held.
- CPU write hit: written into BSRAM in the same cycle unless it loses arbitration. CPU writes are never forwarded by this block; the CPU path to SDRAM is unchanged.
- RV request pending when i_rv_req != o_rv_req_ack. The request is sampled only in IDLE.
- FSM states:
  - IDLE: pending & read & hit -> RD. Pending & write & hit -> WR. Pending & miss -> FWD (toggle o_fwd_rv_req).
  - RD: BSRAM read issued; next cycle -> RDONE.
  - RDONE: capture o_rv_dout, toggle o_rv_req_ack -> IDLE. Total: ack 3 cycles after the request toggle.
  - WR: if a CPU write hit is present this cycle and i_wram_load_ongoing=0, the CPU wins and the FSM stays in WR. Otherwise RV writes the BSRAM, toggles o_fwd_rv_req and goes -> FWD.
  - FWD: wait for i_fwd_rv_ack == o_fwd_rv_req. Then on a read, capture i_fwd_rv_dout into o_rv_dout; toggle o_rv_req_ack -> IDLE.
- Conflict with i_wram_load_ongoing=1: the RV write proceeds and the CPU write is latched into a 1-entry pending buffer. The buffer retires in the next cycle unconditionally. No overflow is possible because RV issues at most one BSRAM write per request.
- At most one BSRAM write per cycle, always.
- A read coincident with a write to the same address returns the old data.
- Miss traffic never touches the BSRAM.
- Address windows: the boundary address BASE+WRAM_BYTES is a miss; BASE+WRAM_BYTES-1 is a hit.
- Reset mid-transaction: FSM returns to IDLE, the pending buffer is discarded, and both toggles are forced to 0. Masters must reset their own request toggles.

Optional Feature:
- WRAM_CONFLICT_STATS_EN defined: o_conflict_count increments on every cycle where a CPU write hit and an RV BSRAM write request coincide. It saturates at 16'hFFFF and clears on reset.
- Undefined: o_conflict_count is tied to 0 and no counter logic is built.

Test Plan:
- CPU write 0xA5 @22'h006010, then CPU read same address -> o_cpu_hit=1, o_cpu_dout=0xA5 one cycle after the read.
- RV read word=0 @23'h066010 after the previous step -> no o_fwd_rv_req toggle; o_rv_dout[7:0]=0xA5; ack toggles 3 cycles after the request.
- RV write wdata=32'h1234_5678, wstrb=4'hF, word=1 @23'h066020 -> BSRAM half = 16'h1234; o_fwd_rv_req toggles; o_rv_req_ack toggles only after i_fwd_rv_ack matches.
- RV read @23'h068000 (miss) -> forwarded; o_rv_dout = i_fwd_rv_dout = 16'hBEEF.
- Same-cycle CPU write hit and RV WR state, load_ongoing=0 -> CPU written first, RV written next cycle. With load_ongoing=1 -> RV first, CPU from the buffer next cycle. Both final values are correct.
- With WRAM_CONFLICT_STATS_EN, the two conflicts above -> o_conflict_count=2. Reset asserted mid-FWD -> all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/wram_shadow_arbiter_if.sv
// CPU, RV and forwarded-SDRAM signal bundle for wram_shadow_arbiter.
// slave = arbiter view, master = view of the surrounding masters / sdram_arbiter.
interface wram_shadow_arbiter_if;
  logic        i_wram_load_ongoing;
  logic [21:0] i_cpu_addr;
  logic        i_cpu_read;
  logic        i_cpu_write;
  logic [7:0]  i_cpu_din;
  logic [7:0]  o_cpu_dout;
  logic        o_cpu_hit;
  logic [22:0] i_rv_addr;
  logic        i_rv_word;
  logic [31:0] i_rv_wdata;
  logic [3:0]  i_rv_wstrb;
  logic        i_rv_req;
  logic        o_rv_req_ack;
  logic [15:0] o_rv_dout;
  logic        o_fwd_rv_req;
  logic        i_fwd_rv_ack;
  logic [15:0] i_fwd_rv_dout;
  logic [15:0] o_conflict_count;

  modport slave (
    input  i_wram_load_ongoing, i_cpu_addr, i_cpu_read, i_cpu_write, i_cpu_din,
    input  i_rv_addr, i_rv_word, i_rv_wdata, i_rv_wstrb, i_rv_req,
    input  i_fwd_rv_ack, i_fwd_rv_dout,
    output o_cpu_dout, o_cpu_hit, o_rv_req_ack, o_rv_dout, o_fwd_rv_req,
    output o_conflict_count
  );

  modport master (
    output i_wram_load_ongoing, i_cpu_addr, i_cpu_read, i_cpu_write, i_cpu_din,
    output i_rv_addr, i_rv_word, i_rv_wdata, i_rv_wstrb, i_rv_req,
    output i_fwd_rv_ack, i_fwd_rv_dout,
    input  o_cpu_dout, o_cpu_hit, o_rv_req_ack, o_rv_dout, o_fwd_rv_req,
    input  o_conflict_count
  );
endinterface

// File: rtl/wram_shadow_arbiter.sv
// BSRAM shadow of the WRAM window shared by NES CPU and RV; RV misses and writes go on to SDRAM.
// Optional macro WRAM_CONFLICT_STATS_EN builds a saturating CPU/RV write-conflict counter.
module wram_shadow_arbiter #(
  parameter logic [21:0] CPU_WRAM_BASE = 22'h006000,
  parameter logic [22:0] RV_WRAM_BASE  = 23'h066000,
  parameter int          WRAM_BYTES    = 8192
) (
  input logic                  i_clk,
  input logic                  i_resetn,
  wram_shadow_arbiter_if.slave bus
);
  localparam int AW   = $clog2(WRAM_BYTES);
  localparam int RW   = AW - 1;
  localparam int ROWS = WRAM_BYTES / 2;
  localparam logic [22:0] CPU_END = 23'(CPU_WRAM_BASE) + 23'(WRAM_BYTES);
  localparam logic [23:0] RV_END  = 24'(RV_WRAM_BASE) + 24'(WRAM_BYTES);

  typedef enum logic [2:0] {IDLE, RD, RDONE, WR, FWD} state_t;

  // Address decode
  logic          cpu_hit, rv_hit, cpu_wr_hit, cpu_rd_hit;
  logic [AW-1:0] cpu_off;
  logic [AW-3:0] rv_off_hi;
  logic [1:0]    cpu_be;

  assign cpu_hit    = (bus.i_cpu_addr >= CPU_WRAM_BASE) && ({1'b0, bus.i_cpu_addr} < CPU_END);
  assign rv_hit     = (bus.i_rv_addr >= RV_WRAM_BASE) && ({1'b0, bus.i_rv_addr} < RV_END);
  assign cpu_off    = bus.i_cpu_addr[AW-1:0] - CPU_WRAM_BASE[AW-1:0];
  assign rv_off_hi  = bus.i_rv_addr[AW-1:2] - RV_WRAM_BASE[AW-1:2];
  assign cpu_wr_hit = bus.i_cpu_write && cpu_hit;
  assign cpu_rd_hit = bus.i_cpu_read && cpu_hit;
  assign cpu_be     = cpu_off[0] ? 2'b10 : 2'b01;

  state_t         state_reg, state_next;
  logic           fwd_req_reg, fwd_req_next;
  logic           ack_reg, ack_next;
  logic [15:0]    rv_dout_reg, rv_dout_next;
  logic           rv_is_rd_reg, rv_is_rd_next;
  logic [RW-1:0]  rv_half_reg, rv_half_next;
  logic [15:0]    rv_wdata_reg, rv_wdata_next;
  logic [1:0]     rv_be_reg, rv_be_next;
  logic           pend_valid_reg, pend_valid_next;
  logic [RW-1:0]  pend_row_reg, pend_row_next;
  logic [1:0]     pend_be_reg, pend_be_next;
  logic [15:0]    pend_data_reg, pend_data_next;
  logic           cpu_hit_reg, cpu_lane_reg, cpu_dout_valid_reg;

  logic           rv_wr_go, rv_rd_en;
  logic [1:0]     wr_en;
  logic [RW-1:0]  wr_row;
  logic [15:0]    wr_data;
  logic [15:0]    cpu_rd_data, rv_rd_data;

  // RV request FSM
  always_comb begin
    state_next    = state_reg;
    fwd_req_next  = fwd_req_reg;
    ack_next      = ack_reg;
    rv_dout_next  = rv_dout_reg;
    rv_is_rd_next = rv_is_rd_reg;
    rv_half_next  = rv_half_reg;
    rv_wdata_next = rv_wdata_reg;
    rv_be_next    = rv_be_reg;
    rv_wr_go      = 1'b0;
    rv_rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.i_rv_req != ack_reg) begin
          rv_is_rd_next = (bus.i_rv_wstrb == 4'h0);
          rv_half_next  = {rv_off_hi, bus.i_rv_word};
          rv_wdata_next = bus.i_rv_word ? bus.i_rv_wdata[31:16] : bus.i_rv_wdata[15:0];
          rv_be_next    = bus.i_rv_word ? bus.i_rv_wstrb[3:2] : bus.i_rv_wstrb[1:0];
          if (!rv_hit) begin
            fwd_req_next = ~fwd_req_reg;
            state_next   = FWD;
          end else if (bus.i_rv_wstrb == 4'h0) begin
            state_next = RD;
          end else begin
            state_next = WR;
          end
        end
      end
      RD: begin
        rv_rd_en   = 1'b1;
        state_next = RDONE;
      end
      RDONE: begin
        rv_dout_next = rv_rd_data;
        ack_next     = ~ack_reg;
        state_next   = IDLE;
      end
      WR: begin
        // The CPU has no stall path, so it only yields while a WRAM load is running.
        if (!(cpu_wr_hit && !bus.i_wram_load_ongoing)) begin
          rv_wr_go     = 1'b1;
          fwd_req_next = ~fwd_req_reg;
          state_next   = FWD;
        end
      end
      FWD: begin
        if (bus.i_fwd_rv_ack == fwd_req_reg) begin
          if (rv_is_rd_reg) rv_dout_next = bus.i_fwd_rv_dout;
          ack_next   = ~ack_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single BSRAM write port: RV winner, then buffered CPU write, then a live CPU write.
  always_comb begin
    wr_en           = 2'b00;
    wr_row          = '0;
    wr_data         = '0;
    pend_valid_next = 1'b0;
    pend_row_next   = pend_row_reg;
    pend_be_next    = pend_be_reg;
    pend_data_next  = pend_data_reg;
    if (rv_wr_go) begin
      wr_en   = rv_be_reg;
      wr_row  = rv_half_reg;
      wr_data = rv_wdata_reg;
    end else if (pend_valid_reg) begin
      wr_en   = pend_be_reg;
      wr_row  = pend_row_reg;
      wr_data = pend_data_reg;
    end else if (cpu_wr_hit) begin
      wr_en   = cpu_be;
      wr_row  = cpu_off[AW-1:1];
      wr_data = {bus.i_cpu_din, bus.i_cpu_din};
    end
    if (cpu_wr_hit && (rv_wr_go || pend_valid_reg)) begin
      pend_valid_next = 1'b1;
      pend_row_next   = cpu_off[AW-1:1];
      pend_be_next    = cpu_be;
      pend_data_next  = {bus.i_cpu_din, bus.i_cpu_din};
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_reg          <= IDLE;
      fwd_req_reg        <= 1'b0;
      ack_reg            <= 1'b0;
      rv_dout_reg        <= '0;
      rv_is_rd_reg       <= 1'b0;
      rv_half_reg        <= '0;
      rv_wdata_reg       <= '0;
      rv_be_reg          <= '0;
      pend_valid_reg     <= 1'b0;
      pend_row_reg       <= '0;
      pend_be_reg        <= '0;
      pend_data_reg      <= '0;
      cpu_hit_reg        <= 1'b0;
      cpu_lane_reg       <= 1'b0;
      cpu_dout_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fwd_req_reg    <= fwd_req_next;
      ack_reg        <= ack_next;
      rv_dout_reg    <= rv_dout_next;
      rv_is_rd_reg   <= rv_is_rd_next;
      rv_half_reg    <= rv_half_next;
      rv_wdata_reg   <= rv_wdata_next;
      rv_be_reg      <= rv_be_next;
      pend_valid_reg <= pend_valid_next;
      pend_row_reg   <= pend_row_next;
      pend_be_reg    <= pend_be_next;
      pend_data_reg  <= pend_data_next;
      cpu_hit_reg    <= cpu_rd_hit;
      if (cpu_rd_hit) begin
        cpu_lane_reg       <= cpu_off[0];
        cpu_dout_valid_reg <= 1'b1;
      end
    end
  end

  // One byte-lane RAM per lane; read registers update only when read, so data holds.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [ROWS];
      logic [7:0] cpu_q_reg;
      logic [7:0] rv_q_reg;
      always_ff @(posedge i_clk) begin
        if (wr_en[gi]) mem[wr_row] <= wr_data[8*gi +: 8];
        if (cpu_rd_hit) cpu_q_reg <= mem[cpu_off[AW-1:1]];
        if (rv_rd_en) rv_q_reg <= mem[rv_half_reg];
      end
      assign cpu_rd_data[8*gi +: 8] = cpu_q_reg;
      assign rv_rd_data[8*gi +: 8]  = rv_q_reg;
    end
  endgenerate

  // The RAM read register has no reset; mask it until the first hit read.
  assign bus.o_cpu_dout   = !cpu_dout_valid_reg ? 8'h00 :
                            (cpu_lane_reg ? cpu_rd_data[15:8] : cpu_rd_data[7:0]);
  assign bus.o_cpu_hit    = cpu_hit_reg;
  assign bus.o_rv_req_ack = ack_reg;
  assign bus.o_rv_dout    = rv_dout_reg;
  assign bus.o_fwd_rv_req = fwd_req_reg;

`ifdef WRAM_CONFLICT_STATS_EN
  logic        conflict;
  logic [15:0] conflict_count_reg;
  assign conflict = cpu_wr_hit && (state_reg == WR);
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      conflict_count_reg <= '0;
    end else if (conflict && (conflict_count_reg != 16'hFFFF)) begin
      conflict_count_reg <= conflict_count_reg + 16'd1;
    end
  end
  assign bus.o_conflict_count = conflict_count_reg;
`else
  assign bus.o_conflict_count = 16'h0000;
`endif
endmodule

// File: tb/tb_wram_shadow_arbiter.sv
// Scoreboard bench for wram_shadow_arbiter: stimulus queues expected responses,
// a negedge monitor pops them when o_cpu_hit is high or o_rv_req_ack toggles.
module tb_wram_shadow_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wram_shadow_arbiter_if bus();
  wram_shadow_arbiter dut (.i_clk(clk), .i_resetn(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] dout;
    int          lat;
  } rv_exp_t;

  int          n_vec = 0;
  int          n_fail = 0;
  int          cycle = 0;
  int          req_cycle = 0;
  logic [15:0] rv_model = 16'h0000;
  logic        last_ack = 1'b0;
  rv_exp_t     rv_q[$];
  logic [7:0]  cpu_q[$];

  always @(posedge clk) cycle++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cycle);
    end
  endtask

  always @(negedge clk) begin : monitor
    rv_exp_t    e;
    logic [7:0] c;
    if (!rst_n) begin
      last_ack = bus.o_rv_req_ack;
    end else begin
      if (bus.o_cpu_hit) begin
        if (cpu_q.size() == 0) check("cpu_unexpected_hit", 32'd1, 32'd0);
        else begin
          c = cpu_q.pop_front();
          check("cpu_dout", 32'(bus.o_cpu_dout), 32'(c));
        end
      end
      if (bus.o_rv_req_ack != last_ack) begin
        last_ack = bus.o_rv_req_ack;
        if (rv_q.size() == 0) check("rv_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = rv_q.pop_front();
          check("rv_dout", 32'(bus.o_rv_dout), 32'(e.dout));
          if (e.lat != 0) check("rv_ack_latency", 32'(cycle - req_cycle), 32'(e.lat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_cpu_dout"}, 32'(bus.o_cpu_dout), 32'd0);
    check({tag, "_cpu_hit"}, 32'(bus.o_cpu_hit), 32'd0);
    check({tag, "_rv_ack"}, 32'(bus.o_rv_req_ack), 32'd0);
    check({tag, "_rv_dout"}, 32'(bus.o_rv_dout), 32'd0);
    check({tag, "_fwd_req"}, 32'(bus.o_fwd_rv_req), 32'd0);
    check({tag, "_conflicts"}, 32'(bus.o_conflict_count), 32'd0);
  endtask

  task automatic cpu_write(input logic [21:0] a, input logic [7:0] d);
    bus.i_cpu_addr  = a;
    bus.i_cpu_din   = d;
    bus.i_cpu_write = 1'b1;
    tick();
    bus.i_cpu_write = 1'b0;
  endtask

  task automatic cpu_read_hit(input logic [21:0] a, input logic [7:0] exp);
    bus.i_cpu_addr = a;
    bus.i_cpu_read = 1'b1;
    cpu_q.push_back(exp);
    tick();
    bus.i_cpu_read = 1'b0;
    tick();
  endtask

  task automatic cpu_read_miss(input logic [21:0] a, input logic [7:0] held);
    bus.i_cpu_addr = a;
    bus.i_cpu_read = 1'b1;
    tick();
    bus.i_cpu_read = 1'b0;
    check("cpu_miss_hit", 32'(bus.o_cpu_hit), 32'd0);
    check("cpu_miss_dout_held", 32'(bus.o_cpu_dout), 32'(held));
  endtask

  task automatic rv_issue(input logic [22:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    bus.i_rv_addr  = a;
    bus.i_rv_word  = w;
    bus.i_rv_wdata = d;
    bus.i_rv_wstrb = s;
    bus.i_rv_req   = ~bus.i_rv_req;
    req_cycle      = cycle;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (bus.o_rv_req_ack != bus.i_rv_req && n < 50) begin
      tick();
      n++;
    end
    check("rv_ack_arrives", 32'(bus.o_rv_req_ack == bus.i_rv_req), 32'd1);
    tick();
  endtask

  task automatic wait_fwd();
    int n = 0;
    while (bus.o_fwd_rv_req == bus.i_fwd_rv_ack && n < 50) begin
      tick();
      n++;
    end
    check("fwd_req_toggle", 32'(bus.o_fwd_rv_req != bus.i_fwd_rv_ack), 32'd1);
  endtask

  task automatic fwd_serve(input logic [15:0] rdata);
    wait_fwd();
    repeat (3) tick();
    check("ack_waits_for_fwd", 32'(bus.o_rv_req_ack != bus.i_rv_req), 32'd1);
    bus.i_fwd_rv_dout = rdata;
    bus.i_fwd_rv_ack  = bus.o_fwd_rv_req;
    wait_ack();
  endtask

  task automatic rv_read_hit(input logic [22:0] a, input logic w, input logic [15:0] exp);
    logic fwd_before;
    rv_exp_t e;
    fwd_before = bus.o_fwd_rv_req;
    e.dout = exp;
    e.lat  = 3;
    rv_q.push_back(e);
    rv_model = exp;
    rv_issue(a, w, 32'h0, 4'h0);
    wait_ack();
    check("rv_hit_not_forwarded", 32'(bus.o_fwd_rv_req), 32'(fwd_before));
  endtask

  task automatic rv_read_miss(input logic [22:0] a, input logic w, input logic [15:0] rdata);
    rv_exp_t e;
    e.dout = rdata;
    e.lat  = 0;
    rv_q.push_back(e);
    rv_model = rdata;
    rv_issue(a, w, 32'h0, 4'h0);
    fwd_serve(rdata);
  endtask

  // Writes must leave o_rv_dout alone even though SDRAM returns data.
  task automatic rv_write_hit(input logic [22:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    rv_exp_t e;
    e.dout = rv_model;
    e.lat  = 0;
    rv_q.push_back(e);
    rv_issue(a, w, d, s);
    fwd_serve(16'hDEAD);
  endtask

  task automatic conflict(input logic [22:0] ra, input logic [31:0] rd,
                          input logic [21:0] ca, input logic [7:0] cd, input logic load);
    rv_exp_t e;
    bus.i_wram_load_ongoing = load;
    e.dout = rv_model;
    e.lat  = 0;
    rv_q.push_back(e);
    rv_issue(ra, 1'b0, rd, 4'h3);
    tick();
    cpu_write(ca, cd);
    fwd_serve(16'hDEAD);
    bus.i_wram_load_ongoing = 1'b0;
  endtask

  initial begin
    bus.i_wram_load_ongoing = 1'b0;
    bus.i_cpu_addr    = '0;
    bus.i_cpu_read    = 1'b0;
    bus.i_cpu_write   = 1'b0;
    bus.i_cpu_din     = '0;
    bus.i_rv_addr     = '0;
    bus.i_rv_word     = 1'b0;
    bus.i_rv_wdata    = '0;
    bus.i_rv_wstrb    = '0;
    bus.i_rv_req      = 1'b0;
    bus.i_fwd_rv_ack  = 1'b0;
    bus.i_fwd_rv_dout = '0;

    repeat (3) tick();
    reset_check("reset");
    rst_n = 1'b1;
    tick();

    cpu_write(22'h006010, 8'hA5);
    cpu_write(22'h006011, 8'h3C);
    cpu_read_hit(22'h006010, 8'hA5);
    rv_read_hit(23'h066010, 1'b0, 16'h3CA5);

    rv_write_hit(23'h066020, 1'b1, 32'h1234_5678, 4'hF);
    cpu_read_hit(22'h006022, 8'h34);
    cpu_read_hit(22'h006023, 8'h12);
    rv_read_hit(23'h066020, 1'b1, 16'h1234);

    rv_read_miss(23'h068000, 1'b0, 16'hBEEF);

    cpu_write(22'h007FFE, 8'h77);
    cpu_write(22'h007FFF, 8'h5A);
    cpu_read_hit(22'h007FFF, 8'h5A);
    cpu_read_miss(22'h008000, 8'h5A);
    cpu_read_miss(22'h005FFF, 8'h5A);
    cpu_write(22'h006000, 8'h11);
    cpu_write(22'h008000, 8'hEE);
    cpu_read_hit(22'h006000, 8'h11);
    rv_read_hit(23'h067FFC, 1'b1, 16'h5A77);

    // load_ongoing=0: CPU lands first, RV overwrites the same byte next cycle.
    conflict(23'h066030, 32'h0000_BBAA, 22'h006030, 8'h55, 1'b0);
    cpu_read_hit(22'h006030, 8'hAA);
    cpu_read_hit(22'h006031, 8'hBB);
    // load_ongoing=1: RV lands first, buffered CPU byte overwrites it next cycle.
    conflict(23'h066040, 32'h0000_DDCC, 22'h006040, 8'h66, 1'b1);
    cpu_read_hit(22'h006040, 8'h66);
    cpu_read_hit(22'h006041, 8'hDD);
`ifdef WRAM_CONFLICT_STATS_EN
    check("conflict_count", 32'(bus.o_conflict_count), 32'd2);
`else
    check("conflict_count_tied", 32'(bus.o_conflict_count), 32'd0);
`endif

    rv_issue(23'h070000, 1'b0, 32'h0, 4'h0);
    wait_fwd();
    tick();
    rst_n = 1'b0;
    #1;
    reset_check("midfwd_reset");
    tick();
    bus.i_rv_req     = 1'b0;
    bus.i_fwd_rv_ack = 1'b0;
    rv_model         = 16'h0000;
    rst_n            = 1'b1;
    tick();
    rv_read_hit(23'h066010, 1'b0, 16'h3CA5);

    repeat (3) tick();
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    check("rv_queue_drained", 32'(rv_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
